uart_cmd_mode_ctrl: RTL
=======================

Name: uart_cmd_mode_ctrl

Overview:
Parametrised command-driven mode controller for the UART TX path.
- Parses received ASCII command bytes, qualified by a valid strobe, and moves between IDLE, NORMAL and CONTROL modes.
- Maintains a per-channel rate-code table for NUM_CH transmit channels.
- Adds channel select, restore-defaults, an inactivity timeout in control mode, and an error pulse for unknown commands.
- Sits between the UART RX byte output and the TX rate/mode consumers.

Parameters:
NUM_CH, 4, number of TX channels with independent rate codes (1..10)
CH_W, 2, channel index width; 2**CH_W >= NUM_CH
TIMEOUT_CYC, 1000000, idle cycles in control mode before forced exit (>= 2)
TO_W, 20, timeout counter width; TIMEOUT_CYC < 2**TO_W
DEFAULT_RATE, 8'h31, reset/restore rate code for every channel

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
i_valid  input  1  one-cycle strobe, i_data holds a received byte
i_data  input  8  received ASCII byte; ignored when i_valid=0
i_start  input  1  level request to leave IDLE for NORMAL
o_mode_idle  output  1  state is IDLE
o_mode_normal  output  1  state is NORMAL
o_mode_ctrl  output  1  state is CTRL or CTRL_SEL
o_sel_ch  output  CH_W  currently selected channel
o_rate  output  8*NUM_CH  rate table; channel k occupies [8k+7:8k]
o_cfg_update  output  1  one-cycle pulse, rate table written
o_err  output  1  one-cycle pulse, unrecognised/invalid byte in control states
o_timeout  output  1  one-cycle pulse, control-mode timeout fired

Behaviour:
- Reset (reset, asynchronous, active-low; clock clk): state IDLE, o_mode_idle=1, other mode flags 0, o_sel_ch=0, every channel = DEFAULT_RATE, pulses 0, timeout counter 0. Reset asserted mid-operation aborts immediately; no partial table write survives.
- All outputs are registered. A byte sampled at edge k is reflected in state, flags, table and pulses after edge k (1-cycle latency).
- Mode flags are mutually exclusive and decoded from the state register.
- Only bytes with i_valid=1 are interpreted; case-insensitive letters below accept upper or lower case.
- IDLE:
  - valid 'M' -> CTRL.
  - else i_start=1 -> NORMAL.
  - 'M' has priority over i_start in the same cycle.
  - Other bytes are ignored; no o_err.
- NORMAL:
  - valid 'M' -> CTRL.
  - valid 'C' -> IDLE.
  - Other bytes are ignored.
- CTRL:
  - '1' -> write 8'h31 to selected channel.
  - '5' -> write 8'h35.
  - 'A'/'a' -> write 8'h61.
  - 'D' -> write DEFAULT_RATE to all channels.
  - 'S' -> CTRL_SEL.
  - 'F' -> NORMAL.
  - Any other byte -> o_err pulse, stay in CTRL.
  - Every table write produces one o_cfg_update pulse.
- CTRL_SEL:
  - Byte 8'h30+n with n < NUM_CH -> o_sel_ch=n, return to CTRL.
  - Any other byte -> o_err, o_sel_ch unchanged, return to CTRL.
- Timeout:
  - Counter runs only in CTRL/CTRL_SEL.
  - Cleared on every valid byte and on entry to CTRL.
  - Increments each cycle without i_valid.
  - When the count reaches TIMEOUT_CYC-1 with no valid byte: o_timeout pulse, state -> NORMAL, counter cleared.
  - If a valid byte arrives in that same cycle, the byte wins and the timeout does not fire.
- Rate table and o_sel_ch persist across all mode changes; only reset or 'D' restores defaults.
- Undefined state encodings recover to IDLE on the next edge.

Test Plan:
- Reset, then release reset -> o_mode_idle=1, o_rate={4{8'h31}}, o_sel_ch=0. Pulse i_start -> o_mode_normal=1 one cycle later.
- IDLE: send 'm' with i_start=1 in the same cycle -> CTRL, not NORMAL. Send 'S','2','A','F' -> o_sel_ch=2, o_rate[23:16]=8'h61, one o_cfg_update, then NORMAL. Send 'C' -> IDLE with table retained.
- CTRL: send 'S','7' with NUM_CH=4 -> o_err pulse, o_sel_ch unchanged, state CTRL. Send 'x' -> o_err, state CTRL. Send '5' -> selected channel = 8'h35. Send 'D' -> all channels 8'h31, o_cfg_update pulse.
- TIMEOUT_CYC=16: enter CTRL, no bytes -> o_timeout pulse and NORMAL exactly 16 cycles after entry. Repeat with a byte at cycle 15 -> no timeout, counter restarts.
- Assert reset asynchronously mid-CTRL during a '1' write -> outputs return to reset values immediately; table = defaults.
- In NORMAL, send 'F' and '1' -> ignored: no o_err, no table change.

Source files
------------

// File: rtl/uart_cmd_mode_ctrl.sv
// uart_cmd_mode_ctrl: ASCII command parser driving UART TX mode and per-channel rate codes.
// Letters are matched case-insensitively; digits select channels in CTRL_SEL.
module uart_cmd_mode_ctrl #(
    parameter int NUM_CH = 4,
    parameter int CH_W = 2,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TO_W = 20,
    parameter logic [7:0] DEFAULT_RATE = 8'h31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic [7:0]            i_data,
    input  logic                  i_start,
    output logic                  o_mode_idle,
    output logic                  o_mode_normal,
    output logic                  o_mode_ctrl,
    output logic [CH_W-1:0]       o_sel_ch,
    output logic [8*NUM_CH-1:0]   o_rate,
    output logic                  o_cfg_update,
    output logic                  o_err,
    output logic                  o_timeout
);
    typedef enum logic [1:0] {IDLE, NORMAL, CTRL, CTRL_SEL} state_t;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0] SEL_END = 8'(8'h30 + NUM_CH);
    state_t state;
    logic [TO_W-1:0] cnt;
    logic [7:0] up;
    logic [7:0] code;
    always_comb begin
        up = (i_data >= "a" && i_data <= "z") ? i_data - 8'd32 : i_data;
        code = (up == "1") ? 8'h31 : (up == "5") ? 8'h35 : 8'h61;
    end
    assign o_mode_idle = state == IDLE;
    assign o_mode_normal = state == NORMAL;
    assign o_mode_ctrl = state == CTRL || state == CTRL_SEL;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            o_sel_ch <= '0;
            o_rate <= {NUM_CH{DEFAULT_RATE}};
            o_cfg_update <= 1'b0;
            o_err <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_cfg_update <= 1'b0;
            o_err <= 1'b0;
            o_timeout <= 1'b0;
            cnt <= '0;
            case (state)
                IDLE: begin
                    if (i_valid && up == "M") state <= CTRL;
                    else if (i_start) state <= NORMAL;
                end
                NORMAL: begin
                    if (i_valid && up == "M") state <= CTRL;
                    else if (i_valid && up == "C") state <= IDLE;
                end
                CTRL, CTRL_SEL: begin
                    // a byte in the final cycle suppresses the timeout
                    if (!i_valid) begin
                        if (cnt == TO_LAST) begin
                            o_timeout <= 1'b1;
                            state <= NORMAL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (state == CTRL) begin
                        case (up)
                            "1", "5", "A": begin
                                for (int k = 0; k < NUM_CH; k++)
                                    if (k == int'(o_sel_ch)) o_rate[8*k +: 8] <= code;
                                o_cfg_update <= 1'b1;
                            end
                            "D": begin
                                o_rate <= {NUM_CH{DEFAULT_RATE}};
                                o_cfg_update <= 1'b1;
                            end
                            "S": state <= CTRL_SEL;
                            "F": state <= NORMAL;
                            default: o_err <= 1'b1;
                        endcase
                    end else begin
                        if (i_data >= 8'h30 && i_data < SEL_END) o_sel_ch <= i_data[CH_W-1:0];
                        else o_err <= 1'b1;
                        state <= CTRL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
